// File: rtl/branch_unit.sv
// Branch resolution unit: decodes the branch condition, computes the target,
// hands a redirect to fetch and then holds flush for a fixed number of cycles.
module branch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned FLAG_W    = 6,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [3:0]        cc_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic              abs_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  input  logic              fetch_ready_i,
  output logic              flush_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  localparam int unsigned FCNT_W = 4;
  // Value loaded into the flush counter on handshake; unused when FLUSH_CYC is 0.
  localparam logic [FCNT_W-1:0] FLUSH_INIT =
    (FLUSH_CYC == 0) ? FCNT_W'(0) : FCNT_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e              state_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic                ready_q;
  logic                redirect_valid_q;
  logic                flush_q;
  logic [ADDR_W-1:0]   redirect_addr_q;
  logic [CNT_W-1:0]    taken_cnt_q;
  logic [CNT_W-1:0]    taken_cnt_d;

  logic                cond_c;
  logic                taken_c;
  logic                accept_c;
  logic [ADDR_W-1:0]   dest_c;

  // Base condition select from the low three condition-code bits.
  always_comb begin
    cond_c = 1'b0;
    case (cc_i[2:0])
      3'b000:  cond_c = 1'b1;
      3'b001:  cond_c = flags_i[5];
      3'b010:  cond_c = flags_i[4];
      3'b011:  cond_c = flags_i[3];
      3'b100:  cond_c = flags_i[2];
      3'b101:  cond_c = flags_i[1];
      3'b110:  cond_c = flags_i[0];
      default: cond_c = 1'b0;
    endcase
  end

  assign taken_c  = cond_c ^ cc_i[3];
  assign accept_c = valid_i && ready_q;

  // Relative target wraps modulo 2^ADDR_W; the pc is zero-extended first.
  assign dest_c = abs_i ? src_i : (ADDR_W'(pc_i) + src_i);

  // Saturating taken counter.
  assign taken_cnt_d = (taken_cnt_q == {CNT_W{1'b1}}) ? taken_cnt_q
                                                      : taken_cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      ready_q          <= 1'b1;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_addr_q  <= '0;
      taken_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Not-taken requests are consumed without touching any state.
          if (accept_c && taken_c) begin
            state_q          <= REDIRECT;
            redirect_addr_q  <= dest_c;
            taken_cnt_q      <= taken_cnt_d;
            ready_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end
        end
        REDIRECT: begin
          if (fetch_ready_i) begin
            redirect_valid_q <= 1'b0;
            if (FLUSH_CYC == 0) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= FLUSH;
              fcnt_q  <= FLUSH_INIT;
              flush_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - FCNT_W'(1);
          end
        end
        default: begin
          state_q          <= IDLE;
          fcnt_q           <= '0;
          ready_q          <= 1'b1;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o          = ready_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign flush_o          = flush_q;
  assign taken_cnt_o      = taken_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: default instance plus a CNT_W=2, FLUSH_CYC=0
// instance for counter saturation and the no-flush return path.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic [15:0] pc;
  logic [3:0]  cc;
  logic [5:0]  flags;
  logic [31:0] src;
  logic        abs_m;
  logic        fetch_ready;

  logic        ready0, rv0, fl0;
  logic [31:0] addr0;
  logic [15:0] cnt0;
  logic        ready1, rv1, fl1;
  logic [31:0] addr1;
  logic [1:0]  cnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_unit u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ready_o(ready0),
    .pc_i(pc), .cc_i(cc), .flags_i(flags), .src_i(src), .abs_i(abs_m),
    .redirect_valid_o(rv0), .redirect_addr_o(addr0),
    .fetch_ready_i(fetch_ready), .flush_o(fl0), .taken_cnt_o(cnt0)
  );

  branch_unit #(.CNT_W(2), .FLUSH_CYC(0)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ready_o(ready1),
    .pc_i(pc), .cc_i(cc), .flags_i(flags), .src_i(src), .abs_i(abs_m),
    .redirect_valid_o(rv1), .redirect_addr_o(addr1),
    .fetch_ready_i(fetch_ready), .flush_o(fl1), .taken_cnt_o(cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_u0(input string tag, input logic rdy, input logic rv,
                        input logic fl, input logic [15:0] cnt);
    chk({tag, ".ready"}, 64'(ready0), 64'(rdy));
    chk({tag, ".rv"},    64'(rv0),    64'(rv));
    chk({tag, ".flush"}, 64'(fl0),    64'(fl));
    chk({tag, ".cnt"},   64'(cnt0),   64'(cnt));
  endtask

  initial begin
    rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1;
    pc = 16'h0010; cc = 4'b0000; flags = 6'b0; src = 32'h20; abs_m = 1'b0;
    fetch_ready = 1'b1;

    // Reset wins over a same-cycle taken request
    tick(); tick();
    chk_u0("reset", 1'b1, 1'b0, 1'b0, 16'd0);
    chk("reset.addr", 64'(addr0), 64'h0);
    chk("reset.u1rdy", 64'(ready1), 64'h1);
    rst = 1'b0; valid1 = 1'b0;

    // Relative taken: 0x10 + 0x20
    tick();
    chk_u0("rel.acc", 1'b0, 1'b1, 1'b0, 16'd1);
    chk("rel.addr", 64'(addr0), 64'h30);
    valid0 = 1'b0;
    tick(); chk_u0("rel.fl1", 1'b0, 1'b0, 1'b1, 16'd1);
    tick(); chk_u0("rel.fl2", 1'b0, 1'b0, 1'b1, 16'd1);
    tick(); chk_u0("rel.done", 1'b1, 1'b0, 1'b0, 16'd1);

    // Absolute with fetch stall; requests during the stall are ignored
    src = 32'hDEAD_BEE0; abs_m = 1'b1; cc = 4'b1111; fetch_ready = 1'b0; valid0 = 1'b1;
    tick();
    chk_u0("abs.acc", 1'b0, 1'b1, 1'b0, 16'd2);
    chk("abs.addr", 64'(addr0), 64'hDEAD_BEE0);
    src = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_u0("abs.stall", 1'b0, 1'b1, 1'b0, 16'd2);
      chk("abs.stall.addr", 64'(addr0), 64'hDEAD_BEE0);
    end
    fetch_ready = 1'b1; valid0 = 1'b0;
    tick(); chk_u0("abs.fl1", 1'b0, 1'b0, 1'b1, 16'd2);
    tick(); chk_u0("abs.fl2", 1'b0, 1'b0, 1'b1, 16'd2);
    tick(); chk_u0("abs.done", 1'b1, 1'b0, 1'b0, 16'd2);
    chk("abs.hold", 64'(addr0), 64'hDEAD_BEE0);

    // Condition sweep with only flag bit 5 set
    flags = 6'b100000; abs_m = 1'b0; pc = 16'h0000; src = 32'h100;
    valid0 = 1'b1; cc = 4'b1001;
    tick(); chk_u0("cc1001", 1'b1, 1'b0, 1'b0, 16'd2);
    cc = 4'b0111;
    tick(); chk_u0("cc0111", 1'b1, 1'b0, 1'b0, 16'd2);
    chk("cc.addr", 64'(addr0), 64'hDEAD_BEE0);
    cc = 4'b0001;
    tick(); chk_u0("cc0001", 1'b0, 1'b1, 1'b0, 16'd3);
    chk("cc0001.addr", 64'(addr0), 64'h100);
    valid0 = 1'b0;
    tick(); tick(); tick();
    chk_u0("cc0001.done", 1'b1, 1'b0, 1'b0, 16'd3);
    valid0 = 1'b1; cc = 4'b1111;
    tick(); chk_u0("cc1111", 1'b0, 1'b1, 1'b0, 16'd4);
    valid0 = 1'b0;
    tick(); tick(); tick();
    chk_u0("cc1111.done", 1'b1, 1'b0, 1'b0, 16'd4);

    // Address wrap, then reset in the first flush cycle
    pc = 16'hFFFF; src = 32'hFFFF_0001; cc = 4'b0000; valid0 = 1'b1;
    tick(); chk_u0("wrap.acc", 1'b0, 1'b1, 1'b0, 16'd5);
    chk("wrap.addr", 64'(addr0), 64'h0);
    valid0 = 1'b0;
    tick(); chk_u0("mid.fl1", 1'b0, 1'b0, 1'b1, 16'd5);
    rst = 1'b1;
    tick(); chk_u0("mid.rst", 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    // Saturation on the 2-bit counter, no-flush return
    pc = 16'h0004; src = 32'h8; abs_m = 1'b0; cc = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      valid1 = 1'b1;
      tick();
      chk("sat.rv", 64'(rv1), 64'h1);
      chk("sat.cnt", 64'(cnt1), (k >= 3) ? 64'd3 : 64'(k));
      valid1 = 1'b0;
      tick();
      chk("sat.rdy", 64'(ready1), 64'h1);
      chk("sat.fl", 64'(fl1), 64'h0);
    end
    chk("sat.addr", 64'(addr1), 64'hC);
    valid1 = 1'b1; cc = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b.rdy", 64'(ready1), 64'h1);
      chk("b2b.rv", 64'(rv1), 64'h0);
      chk("b2b.cnt", 64'(cnt1), 64'd3);
    end
    valid1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning destination/source address width.
REQ-002 SHALL have parameter PC_W, default 16, meaning program counter width (PC_W <= ADDR_W).
REQ-003 SHALL have parameter FLAG_W, default 6, meaning flag register width (>= 6).
REQ-004 SHALL have parameter FLUSH_CYC, default 2, meaning flush_o assertion cycles after redirect acceptance (0..15).
REQ-005 SHALL have parameter CNT_W, default 16, meaning width of the taken-branch counter.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk_i  input  1  clock; all state updates on rising edge.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 valid_i  input  1  branch request present.
REQ-010 ready_o  output  1  unit can accept a request this cycle.
REQ-011 pc_i  input  PC_W  program counter of the branch.
REQ-012 cc_i  input  4  condition code; bit 3 inverts the condition.
REQ-013 flags_i  input  FLAG_W  flag register value.
REQ-014 src_i  input  ADDR_W  value of rs.
REQ-015 abs_i  input  1  0 = PC-relative, 1 = absolute.
REQ-016 redirect_valid_o  output  1  redirect request to fetch.
REQ-017 redirect_addr_o  output  ADDR_W  registered destination address.
REQ-018 fetch_ready_i  input  1  fetch accepts the redirect.
REQ-019 flush_o  output  1  kill younger in-flight instructions.
REQ-020 taken_cnt_o  output  CNT_W  count of taken branches since reset.

Function
REQ-021 Request SHALL be accepted on a cycle where valid_i && ready_o; ready_o SHALL be 1 only in state IDLE.
REQ-022 Base condition SHALL be decoded from cc_i[2:0]: 000 -> 1; 001..101 -> flags_i[5]..flags_i[1] respectively; 110 -> flags_i[0]; 111 -> 0.
REQ-023 Taken SHALL equal base condition XOR cc_i[3] (cc 4'b1111 = always, 4'b1000 = never).
REQ-024 Destination SHALL be src_i when abs_i=1, else zero-extended pc_i + src_i truncated to ADDR_W bits (wrap-around modulo 2^ADDR_W, no carry out).
REQ-025 States SHALL be IDLE, REDIRECT and FLUSH.
REQ-026 IDLE: an accepted taken request SHALL latch destination into redirect_addr_o, increment taken_cnt_o, and move to REDIRECT next cycle.
REQ-027 IDLE: an accepted not-taken request SHALL leave all state and outputs unchanged; the unit remains ready (back-to-back requests allowed).
REQ-028 REDIRECT: redirect_valid_o SHALL be 1 and redirect_addr_o stable until fetch_ready_i=1.
REQ-029 REDIRECT with fetch_ready_i=1 SHALL go to FLUSH with flush counter = FLUSH_CYC-1, or directly to IDLE when FLUSH_CYC=0.
REQ-030 FLUSH: flush_o SHALL be 1 for exactly FLUSH_CYC consecutive cycles, then the unit SHALL return to IDLE.
REQ-031 flush_o SHALL be 0 in IDLE and REDIRECT; redirect_valid_o SHALL be 0 outside REDIRECT.
REQ-032 Latency SHALL be: acceptance cycle N -> redirect_valid_o at N+1; handshake at cycle M -> flush_o cycles M+1..M+FLUSH_CYC, ready_o at M+FLUSH_CYC+1.
REQ-033 taken_cnt_o SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-034 valid_i while ready_o=0 SHALL be ignored (no latch, no count).
REQ-035 redirect_addr_o SHALL hold its last value in IDLE and FLUSH.

Reset
REQ-036 On rst_i=1 at a clock edge, state SHALL become IDLE, ready_o=1, redirect_valid_o=0, flush_o=0, redirect_addr_o=0, taken_cnt_o=0, flush counter=0.
REQ-037 rst_i SHALL take priority over every transition, including a pending handshake or mid-flush, and over a same-cycle valid_i.

Verification
REQ-038 Relative taken: pc_i=16'h0010, src_i=32'h0000_0020, abs_i=0, cc_i=4'b0000, fetch_ready_i=1 -> redirect_addr_o=32'h30, redirect_valid_o 1 cycle, flush_o 2 cycles, taken_cnt_o=1.
REQ-039 Absolute with stall: src_i=32'hDEAD_BEE0, abs_i=1, fetch_ready_i=0 for 3 cycles -> redirect_valid_o held 4 cycles with address stable, ready_o=0 throughout.
REQ-040 Condition sweep: flags_i=6'b100000; cc_i=4'b0001 -> taken; 4'b1001 -> not taken; 4'b0111 -> not taken; 4'b1111 -> taken.
REQ-041 Wrap: pc_i=16'hFFFF, src_i=32'hFFFF_0001, abs_i=0 -> redirect_addr_o=32'h0000_0000.
REQ-042 Reset mid-flush: assert rst_i in first flush_o cycle -> next cycle flush_o=0, ready_o=1, taken_cnt_o=0.
REQ-043 Saturation with CNT_W=2: five taken branches -> taken_cnt_o=3; back-to-back not-taken requests accepted every cycle with ready_o=1.
